// File: rtl/lc4_alu_pkg.sv
// Shared opcodes, state encoding and iteration count for the LC4 multiply/divide unit.
// Also holds the opcode-support helper used at operation acceptance.
package lc4_alu_pkg;

    localparam logic [15:0] ALU_CTL_MUL = 16'd1;
    localparam logic [15:0] ALU_CTL_DIV = 16'd3;
    localparam logic [15:0] ALU_CTL_MOD = 16'd4;

    localparam int unsigned ITER_COUNT = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL,
        OP_DIV,
        OP_MOD
    } op_t;

    function automatic logic is_supported(input logic [15:0] ctl);
        return (ctl == ALU_CTL_MUL) || (ctl == ALU_CTL_DIV) || (ctl == ALU_CTL_MOD);
    endfunction

endpackage

// File: rtl/lc4_muldiv_step.sv
// One combinational iteration of the LSB-first shift-add multiplier or the
// MSB-first unsigned restoring divider.
module lc4_muldiv_step
    import lc4_alu_pkg::*;
(
    input  op_t         op,
    input  logic [15:0] acc,
    input  logic [15:0] sh,
    input  logic [15:0] opnd,
    output logic [15:0] acc_nxt,
    output logic [15:0] sh_nxt,
    output logic [15:0] opnd_nxt
);

    logic        no_borrow;
    logic [15:0] rem_sub;

    // Partial remainder is always < divisor, so {acc, bit} can reach 17 bits
    // but the difference after a successful subtract always fits in 16.
    assign no_borrow = ({1'b0, acc, sh[15]} >= {2'b00, opnd});
    assign rem_sub   = {acc[14:0], sh[15]} - opnd;

    always_comb begin
        acc_nxt  = acc;
        sh_nxt   = sh;
        opnd_nxt = opnd;
        if (op == OP_MUL) begin
            if (sh[0]) begin
                acc_nxt = acc + opnd;
            end
            sh_nxt   = {1'b0, sh[15:1]};
            opnd_nxt = {opnd[14:0], 1'b0};
        end else begin
            if (no_borrow) begin
                acc_nxt = rem_sub;
                sh_nxt  = {sh[14:0], 1'b1};
            end else begin
                acc_nxt = {acc[14:0], sh[15]};
                sh_nxt  = {sh[14:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/lc4_alu_muldiv.sv
// Iterative 16-bit MUL/DIV/MOD unit for the LC4 datapath, 16 iterations per op.
// Optional LC4_MULDIV_DIV0_FAST_EN: divide by zero completes without iterating.
module lc4_alu_muldiv
    import lc4_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [15:0] i_alu_ctl,
    input  logic [15:0] i_r1data,
    input  logic [15:0] i_r2data,
    output logic        o_busy,
    output logic        o_valid,
    output logic [15:0] o_result
);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [4:0]  cnt_q;
    logic [15:0] acc_q, sh_q, opnd_q;
    logic [15:0] acc_nxt, sh_nxt, opnd_nxt;
    logic        b_zero_q;
    logic        accept, div0_now, last_iter;
    logic [15:0] final_res;

    lc4_muldiv_step u_step (
        .op       (op_q),
        .acc      (acc_q),
        .sh       (sh_q),
        .opnd     (opnd_q),
        .acc_nxt  (acc_nxt),
        .sh_nxt   (sh_nxt),
        .opnd_nxt (opnd_nxt)
    );

    assign accept    = i_start && is_supported(i_alu_ctl) && (state_q != RUN);
    assign div0_now  = (i_alu_ctl != ALU_CTL_MUL) && (i_r2data == '0);
    assign last_iter = (state_q == RUN) && (cnt_q == 5'(ITER_COUNT - 1));

    always_comb begin
        op_d = OP_MUL;
        if (i_alu_ctl == ALU_CTL_DIV) begin
            op_d = OP_DIV;
        end else if (i_alu_ctl == ALU_CTL_MOD) begin
            op_d = OP_MOD;
        end
    end

    always_comb begin
        final_res = acc_nxt;
        if (op_q != OP_MUL && b_zero_q) begin
            final_res = '0;
        end else if (op_q == OP_DIV) begin
            final_res = sh_nxt;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
`ifdef LC4_MULDIV_DIV0_FAST_EN
                    state_d = div0_now ? DONE : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opnd_q   <= '0;
            b_zero_q <= 1'b0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            state_q <= state_d;
            o_busy  <= (state_d == RUN);
            o_valid <= (state_d == DONE);
            if (accept) begin
                op_q     <= op_d;
                cnt_q    <= '0;
                acc_q    <= '0;
                b_zero_q <= div0_now;
                // MUL shifts the multiplier in sh; DIV/MOD shift the dividend there.
                sh_q     <= (op_d == OP_MUL) ? i_r2data : i_r1data;
                opnd_q   <= (op_d == OP_MUL) ? i_r1data : i_r2data;
`ifdef LC4_MULDIV_DIV0_FAST_EN
                if (div0_now) begin
                    o_result <= '0;
                end
`endif
            end else if (state_q == RUN) begin
                acc_q  <= acc_nxt;
                sh_q   <= sh_nxt;
                opnd_q <= opnd_nxt;
                cnt_q  <= last_iter ? '0 : cnt_q + 5'd1;
                if (last_iter) begin
                    o_result <= final_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_lc4_alu_muldiv.sv
// Scoreboard bench for lc4_alu_muldiv; honours LC4_MULDIV_DIV0_FAST_EN for div-by-zero latency.
module tb_lc4_alu_muldiv;
    import lc4_alu_pkg::*;

`ifdef LC4_MULDIV_DIV0_FAST_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 17;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_alu_ctl = '0;
    logic [15:0] i_r1data = '0;
    logic [15:0] i_r2data = '0;
    logic        o_busy;
    logic        o_valid;
    logic [15:0] o_result;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_res = '0;

    always #5 clk = ~clk;

    lc4_alu_muldiv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .i_alu_ctl (i_alu_ctl),
        .i_r1data  (i_r1data),
        .i_r2data  (i_r2data),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_result  (o_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge; the request is sampled at the following posedge.
    task automatic launch(input logic [15:0] ctl, input logic [15:0] a, input logic [15:0] b,
                          input bit push, input logic [15:0] exp);
        i_start   = 1'b1;
        i_alu_ctl = ctl;
        i_r1data  = a;
        i_r2data  = b;
        if (push) exp_q.push_back(exp);
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input int inject);
        int n = 0;
        int busy_cyc = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) i_start = 1'b0;
            if (inject != 0 && n == inject) begin
                i_start   = 1'b1;
                i_alu_ctl = ALU_CTL_MUL;
                i_r1data  = 16'd3;
                i_r2data  = 16'd3;
            end
            if (inject != 0 && n == inject + 1) i_start = 1'b0;
            if (o_busy) busy_cyc++;
            if (o_valid) seen = 1'b1;
        end
        chk({tag, "_valid"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_busy_cycles"}, busy_cyc, exp_lat - 1);
        if (seen) begin
            chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk({tag, "_result"}, o_result, exp_q.pop_front());
            last_res = o_result;
        end
    endtask

    task automatic ignored(input string tag, input logic [15:0] ctl);
        int busy_cyc = 0;
        int valid_cyc = 0;
        launch(ctl, 16'd9, 16'd9, 1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_busy) busy_cyc++;
            if (o_valid) valid_cyc++;
        end
        chk({tag, "_busy"}, busy_cyc, 0);
        chk({tag, "_valid"}, valid_cyc, 0);
        chk({tag, "_result_held"}, o_result, last_res);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_result", o_result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        launch(ALU_CTL_MUL, 16'd7, 16'd6, 1'b1, 16'h002A);         wait_done("mul_7x6", 17, 0);
        launch(ALU_CTL_MUL, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0001);   wait_done("mul_ffff", 17, 0);
        launch(ALU_CTL_DIV, 16'd100, 16'd7, 1'b1, 16'h000E);       wait_done("div_100_7", 17, 0);
        launch(ALU_CTL_MOD, 16'd100, 16'd7, 1'b1, 16'h0002);       wait_done("mod_100_7", 17, 0);
        launch(ALU_CTL_MOD, 16'h8000, 16'd3, 1'b1, 16'h0002);      wait_done("mod_8000_3", 17, 0);
        launch(ALU_CTL_DIV, 16'hFFFF, 16'h8001, 1'b1, 16'h0001);   wait_done("div_big", 17, 0);
        launch(ALU_CTL_MOD, 16'hFFFF, 16'h8001, 1'b1, 16'h7FFE);   wait_done("mod_big", 17, 0);
        launch(ALU_CTL_DIV, 16'd5, 16'd0, 1'b1, 16'h0000);         wait_done("div_by0", DIV0_LAT, 0);
        launch(ALU_CTL_MUL, 16'd3, 16'd5, 1'b1, 16'h000F);         wait_done("mul_3x5", 17, 0);
        launch(ALU_CTL_MOD, 16'd5, 16'd0, 1'b1, 16'h0000);         wait_done("mod_by0", DIV0_LAT, 0);

        // Start during RUN is ignored; start in the DONE cycle chains with no gap.
        launch(ALU_CTL_DIV, 16'd100, 16'd7, 1'b1, 16'h000E);       wait_done("div_ignore", 17, 5);
        launch(ALU_CTL_MUL, 16'd3, 16'd3, 1'b1, 16'h0009);         wait_done("mul_b2b", 17, 0);

        ignored("ctl_add", 16'h0000);
        ignored("ctl_0020", 16'h0020);

        launch(ALU_CTL_MUL, 16'd7, 16'd6, 1'b0, '0);
        repeat (8) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        chk("pre_reset_busy", 32'(o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_busy", 32'(o_busy), 32'd0);
        chk("async_reset_valid", 32'(o_valid), 32'd0);
        chk("async_reset_result", o_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(ALU_CTL_MUL, 16'd2, 16'd3, 1'b1, 16'h0006);         wait_done("mul_after_rst", 17, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
